// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants, ALU operation encoding and the EX/MEM register layout.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        misaligned;
    logic        illegal;
  } ex_mem_t;

  // Register forms use instr[30] for SUB; immediate forms only for the SRAI/SRLI split.
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3,
                                                input logic       funct7b5,
                                                input logic       is_reg);
    case (funct3)
      3'b000:  return (is_reg && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU; shift amount is always b[4:0].
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_alu_op,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      ALU_ADD:    o_result = i_a + i_b;
      ALU_SUB:    o_result = i_a - i_b;
      ALU_SLL:    o_result = i_a << w_shamt;
      ALU_SLT:    o_result = {31'b0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU:   o_result = {31'b0, i_a < i_b};
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_SRL:    o_result = i_a >> w_shamt;
      ALU_SRA:    o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:     o_result = i_a | i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_PASS_B: o_result = i_b;
      default:    o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: decode to ALU op, branch compare, target adder and the EX/MEM register.
module execute_stage
  import rv32i_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_VAL = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rd_i,
  output logic            valid_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic            reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            misaligned_o,
  output logic            illegal_o
);

  alu_op_e         w_alu_op;
  logic [XLEN-1:0] w_op_a, w_op_b, w_alu_result, w_target_sum, w_target;
  logic            w_reg_write, w_mem_read, w_mem_write, w_taken, w_illegal, w_is_jalr;
  logic            w_eq, w_lt, w_ltu;
  ex_mem_t         r_ex_mem, w_next;

  assign w_eq  = (rs1_data_i == rs2_data_i);
  assign w_lt  = ($signed(rs1_data_i) < $signed(rs2_data_i));
  assign w_ltu = (rs1_data_i < rs2_data_i);

  assign w_target_sum = (w_is_jalr ? rs1_data_i : pc_i) + imm_i;
  assign w_target     = w_is_jalr ? {w_target_sum[XLEN-1:1], 1'b0} : w_target_sum;

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_op_a      = rs1_data_i;
    w_op_b      = rs2_data_i;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_taken     = 1'b0;
    w_illegal   = 1'b0;
    w_is_jalr   = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        w_alu_op    = alu_op_from_funct(funct3_i, funct7b5_i, 1'b1);
        w_reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        w_alu_op    = alu_op_from_funct(funct3_i, funct7b5_i, 1'b0);
        w_op_b      = imm_i;
        w_reg_write = 1'b1;
      end
      OPC_LUI: begin
        w_alu_op    = ALU_PASS_B;
        w_op_b      = imm_i;
        w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_op_a      = pc_i;
        w_op_b      = imm_i;
        w_reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_op_a      = pc_i;
        w_op_b      = XLEN'(4);
        w_reg_write = 1'b1;
        w_taken     = 1'b1;
        w_is_jalr   = (opcode_i == OPC_JALR);
      end
      OPC_BRANCH: begin
        w_op_a = pc_i;
        w_op_b = imm_i;
        case (funct3_i)
          F3_BEQ:  w_taken = w_eq;
          F3_BNE:  w_taken = !w_eq;
          F3_BLT:  w_taken = w_lt;
          F3_BGE:  w_taken = !w_lt;
          F3_BLTU: w_taken = w_ltu;
          F3_BGEU: w_taken = !w_ltu;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_op_b      = imm_i;
        w_mem_read  = 1'b1;
        w_reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_op_b      = imm_i;
        w_mem_write = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: w_illegal = 1'b1;
    endcase
  end

  rv32i_alu u_alu (
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_alu_op (w_alu_op),
    .o_result (w_alu_result)
  );

  always_comb begin
    w_next               = '0;
    w_next.valid         = 1'b1;
    w_next.alu_result    = w_alu_result;
    w_next.store_data    = w_mem_write ? rs2_data_i : '0;
    w_next.rd            = rd_i;
    w_next.funct3        = funct3_i;
    w_next.reg_write     = w_reg_write && (rd_i != 5'd0);
    w_next.mem_read      = w_mem_read;
    w_next.mem_write     = w_mem_write;
    w_next.branch_taken  = w_taken;
    w_next.branch_target = w_target;
    w_next.misaligned    = w_taken && w_target[1];
    w_next.illegal       = w_illegal;
  end

  // Edge priority is reset > flush > stall > load; an empty slot (valid_i=0)
  // loads as a bubble, so taken/enables are never set while valid_o is 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ex_mem               <= '0;
      r_ex_mem.branch_target <= RESET_PC_VAL;
    end else if (flush_i || (!stall_i && !valid_i)) begin
      r_ex_mem <= '0;
    end else if (!stall_i) begin
      r_ex_mem <= w_next;
    end
  end

  assign valid_o         = r_ex_mem.valid;
  assign alu_result_o    = r_ex_mem.alu_result;
  assign store_data_o    = r_ex_mem.store_data;
  assign rd_o            = r_ex_mem.rd;
  assign funct3_o        = r_ex_mem.funct3;
  assign reg_write_o     = r_ex_mem.reg_write;
  assign mem_read_o      = r_ex_mem.mem_read;
  assign mem_write_o     = r_ex_mem.mem_write;
  assign branch_taken_o  = r_ex_mem.branch_taken;
  assign branch_target_o = r_ex_mem.branch_target;
  assign misaligned_o    = r_ex_mem.misaligned;
  assign illegal_o       = r_ex_mem.illegal;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic against a reference model.
module tb_execute_stage;
  import rv32i_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic        ill;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset, valid, stall, flush;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] pc, rs1, rs2, imm;
  logic [4:0]  rd;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o, misaligned_o, illegal_o;
  logic [31:0] alu_result_o, store_data_o, branch_target_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  ex_t         obs;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .opcode_i(opcode), .funct3_i(funct3), .funct7b5_i(funct7b5), .pc_i(pc),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm), .rd_i(rd),
    .valid_o(valid_o), .alu_result_o(alu_result_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .funct3_o(funct3_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_taken_o(branch_taken_o),
    .branch_target_o(branch_target_o), .misaligned_o(misaligned_o), .illegal_o(illegal_o)
  );

  assign obs = {valid_o, alu_result_o, store_data_o, rd_o, funct3_o, reg_write_o, mem_read_o,
                mem_write_o, branch_taken_o, branch_target_o, misaligned_o, illegal_o};

  // Integer arithmetic for OP / OP-IMM written from the ISA definitions.
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic f7,
                                        input logic [31:0] a, input logic [31:0] b, input bit reg_form);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b[4:0];
    ones = '1;
    case (f3)
      3'd0: return (reg_form && f7) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0)) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Expected EX/MEM entry for one loaded instruction, plus a care mask for undefined fields.
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] i, input logic [4:0] r, output ex_t e, output ex_t m);
    bit writes;
    e = '0; m = '1; m.sdata = '0; m.target = '0;
    e.valid = 1'b1; e.rd = r; e.f3 = f3; writes = 0;
    case (op)
      OPC_OP:     begin e.result = arith(f3, f7, a, b, 1); writes = 1; end
      OPC_OP_IMM: begin e.result = arith(f3, f7, a, i, 0); writes = 1; end
      OPC_LUI:    begin e.result = i; writes = 1; end
      OPC_AUIPC:  begin e.result = p + i; writes = 1; end
      OPC_JAL:    begin e.result = p + 4; writes = 1; e.taken = 1; e.target = p + i; m.target = '1; end
      OPC_JALR:   begin e.result = p + 4; writes = 1; e.taken = 1; e.target = (a + i) & ~32'd1; m.target = '1; end
      OPC_BRANCH: begin
        e.result = p + i; e.target = p + i; m.target = '1;
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = (int'(a) < int'(b));
          3'd5: e.taken = (int'(a) >= int'(b));
          3'd6: e.taken = (a < b);
          3'd7: e.taken = (a >= b);
          default: begin e.ill = 1; m.result = '0; m.target = '0; end
        endcase
      end
      OPC_LOAD:   begin e.result = a + i; e.mr = 1; writes = 1; end
      OPC_STORE:  begin e.result = a + i; e.mw = 1; e.sdata = b; m.sdata = '1; end
      OPC_FENCE, OPC_SYSTEM: m.result = '0;
      default:    begin e.ill = 1; m.result = '0; end
    endcase
    e.rw  = writes && (r != 5'd0);
    e.mis = e.taken && e.target[1];
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i, input logic [4:0] r);
    valid = 1; stall = 0; flush = 0;
    opcode = op; funct3 = f3; funct7b5 = f7; pc = p; rs1 = a; rs2 = b; imm = i; rd = r;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 40);
      2: return 32'hFFFF_FFFF - $urandom_range(0, 40);
      default: return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
  endfunction

  task automatic test_reset();
    ex_t zero;
    zero = '0;
    reset = 1; valid = 0; stall = 0; flush = 0;
    opcode = '0; funct3 = '0; funct7b5 = 0; pc = '0; rs1 = '0; rs2 = '0; imm = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== zero) begin errors++; $display("FAIL reset_init obs=%h exp=%h", obs, zero); end
    reset = 0;
    drive(OPC_JAL, 3'd0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h10, 5'd3);
    reset = 1; stall = 1;
    @(posedge clk); #1;
    checks++;
    if (obs !== zero) begin errors++; $display("FAIL reset_mid obs=%h exp=%h", obs, zero); end
    reset = 0; stall = 0;
  endtask

  task automatic test_alu();
    logic [2:0]  f3s[6]  = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd5, 3'd5};
    logic        f7s[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] bs[6]   = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h4, 32'h4};
    logic [31:0] exps[6] = '{32'h0, 32'hFFFF_FFE0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0FFF_FFFF};
    ex_t e, m;
    for (int k = 0; k < 6; k++) begin
      drive(OPC_OP, f3s[k], f7s[k], 32'h0, 32'hFFFF_FFF0, bs[k], 32'h0, 5'd7);
      model(OPC_OP, f3s[k], f7s[k], 32'h0, 32'hFFFF_FFF0, bs[k], 32'h0, 5'd7, e, m);
      checks++;
      if (alu_result_o !== exps[k] || valid_o !== 1'b1 || reg_write_o !== 1'b1) begin
        errors++; $display("FAIL alu_%0d result=%h valid=%b rw=%b exp=%h", k, alu_result_o, valid_o, reg_write_o, exps[k]);
      end
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL alu_model_%0d obs=%h exp=%h", k, obs & m, e & m); end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3s[3] = '{F3_BEQ, F3_BLTU, F3_BLT};
    logic [31:0] as[3]  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[3]  = '{32'd5, 32'd1, 32'd1};
    logic        tk[3]  = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive(OPC_BRANCH, f3s[k], 1'b0, 32'h100, as[k], bs[k], 32'h20, 5'd9);
      checks++;
      if (branch_taken_o !== tk[k] || branch_target_o !== 32'h120 || reg_write_o !== 1'b0 || misaligned_o !== 1'b0) begin
        errors++;
        $display("FAIL branch_%0d taken=%b target=%h rw=%b mis=%b exp_taken=%b exp_target=120",
                 k, branch_taken_o, branch_target_o, reg_write_o, misaligned_o, tk[k]);
      end
    end
  endtask

  task automatic test_jump();
    drive(OPC_JALR, 3'd0, 1'b0, 32'h40, 32'h203, 32'h0, 32'h0, 5'd1);
    checks++;
    if (branch_target_o !== 32'h202 || alu_result_o !== 32'h44 || misaligned_o !== 1'b1 || branch_taken_o !== 1'b1) begin
      errors++; $display("FAIL jalr target=%h result=%h mis=%b taken=%b exp 202/44/1/1",
                         branch_target_o, alu_result_o, misaligned_o, branch_taken_o);
    end
    drive(OPC_JAL, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8, 5'd1);
    checks++;
    if (branch_target_o !== 32'h8 || alu_result_o !== 32'h4 || misaligned_o !== 1'b0 || branch_taken_o !== 1'b1) begin
      errors++; $display("FAIL jal target=%h result=%h mis=%b taken=%b exp 8/4/0/1",
                         branch_target_o, alu_result_o, misaligned_o, branch_taken_o);
    end
  endtask

  task automatic test_mem_rd0();
    drive(OPC_LOAD, 3'b010, 1'b0, 32'h0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 5'd4);
    checks++;
    if (alu_result_o !== 32'h0FFC || mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || reg_write_o !== 1'b1) begin
      errors++; $display("FAIL lw result=%h mr=%b mw=%b rw=%b exp 0ffc/1/0/1", alu_result_o, mem_read_o, mem_write_o, reg_write_o);
    end
    drive(OPC_STORE, 3'b010, 1'b0, 32'h0, 32'h2000, 32'hDEAD_BEEF, 32'h8, 5'd0);
    checks++;
    if (store_data_o !== 32'hDEAD_BEEF || mem_write_o !== 1'b1 || reg_write_o !== 1'b0 || alu_result_o !== 32'h2008) begin
      errors++; $display("FAIL sw sdata=%h mw=%b rw=%b result=%h exp deadbeef/1/0/2008", store_data_o, mem_write_o, reg_write_o, alu_result_o);
    end
    drive(OPC_OP_IMM, 3'd0, 1'b1, 32'h0, 32'h5, 32'h0, 32'h3, 5'd0);
    checks++;
    if (reg_write_o !== 1'b0 || alu_result_o !== 32'h8) begin
      errors++; $display("FAIL addi_rd0 rw=%b result=%h exp 0/8", reg_write_o, alu_result_o);
    end
  endtask

  task automatic test_stall_flush();
    ex_t e, m, zero;
    zero = '0;
    drive(OPC_JAL, 3'd0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h1C, 5'd2);
    model(OPC_JAL, 3'd0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h1C, 5'd2, e, m);
    for (int k = 0; k < 3; k++) begin
      stall = 1; opcode = OPC_OP; funct3 = 3'd4; rs1 = $urandom; rs2 = $urandom; rd = 5'd11;
      @(posedge clk); #1;
      checks++;
      if ((obs & m) !== (e & m)) begin errors++; $display("FAIL stall_hold_%0d obs=%h exp=%h", k, obs & m, e & m); end
    end
    flush = 1; stall = 1; valid = 1;
    @(posedge clk); #1;
    checks++;
    if (obs !== zero) begin errors++; $display("FAIL flush_stall obs=%h exp=%h", obs, zero); end
    drive(7'h7F, 3'd0, 1'b0, 32'h0, 32'h1, 32'h2, 32'h3, 5'd6);
    checks++;
    if (illegal_o !== 1'b1 || valid_o !== 1'b1 || reg_write_o !== 1'b0 || mem_read_o !== 1'b0 ||
        mem_write_o !== 1'b0 || branch_taken_o !== 1'b0) begin
      errors++; $display("FAIL illegal_opc ill=%b v=%b rw=%b mr=%b mw=%b tk=%b exp 1/1/0/0/0/0",
                         illegal_o, valid_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o);
    end
    drive(OPC_BRANCH, 3'b010, 1'b0, 32'h0, 32'h1, 32'h1, 32'h8, 5'd6);
    checks++;
    if (illegal_o !== 1'b1 || branch_taken_o !== 1'b0 || reg_write_o !== 1'b0) begin
      errors++; $display("FAIL illegal_branch ill=%b tk=%b rw=%b exp 1/0/0", illegal_o, branch_taken_o, reg_write_o);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[13] = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                            OPC_LOAD, OPC_STORE, OPC_FENCE, OPC_SYSTEM, 7'h7F, 7'h0B};
    ex_t e, m, cur_e, cur_m;
    cur_e = '0; cur_m = '1;
    for (int n = 0; n < 600; n++) begin
      opcode = ops[$urandom_range(0, 12)];
      funct3 = 3'($urandom_range(0, 7)); funct7b5 = 1'($urandom_range(0, 1));
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rs1 = pick_val(); rs2 = pick_val(); imm = pick_val(); rd = 5'($urandom_range(0, 31));
      valid = ($urandom_range(0, 9) != 0);
      stall = (n > 0) && ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      model(opcode, funct3, funct7b5, pc, rs1, rs2, imm, rd, e, m);
      if (flush || (!stall && !valid)) begin cur_e = '0; cur_m = '1; end
      else if (!stall) begin cur_e = e; cur_m = m; end
      @(posedge clk); #1;
      checks++;
      if ((obs & cur_m) !== (cur_e & cur_m)) begin
        errors++; $display("FAIL random_%0d op=%h f3=%0d obs=%h exp=%h", n, opcode, funct3, obs & cur_m, cur_e & cur_m);
      end
    end
    valid = 0; stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_mem_rd0();
    test_stall_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
